load_store_unit_mod: RTL and testbench

Initiator-side controller for the pipeline's data memory. It accepts load/store requests from the MEM stage through a valid/ready handshake, drives the word-wide data memory port (combinational read, write on rising clock while write enable is high), and returns load data or store completion. It sign- or zero-extends sub-word loads and performs read-modify-write for sub-word stores, because the memory only writes whole 32-bit words.

---
 rtl/load_store_pkg.sv | 37 +++
 rtl/load_store_lane_mod.sv | 56 +++++
 rtl/load_store_unit_mod.sv | 151 +++++++++++++++
 tb/tb_load_store_unit_mod.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LOAD_STORE_SUBWORD_EN (byte/half access support).
package load_store_pkg;

  localparam int DATA_W = 32;

  // Access size encodings carried on req_size_i
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4,
    ST_ERR    = 3'd5
  } lsu_state_e;

  // True when a request must be rejected: bad size or address not aligned to it.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
`ifdef LOAD_STORE_SUBWORD_EN
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
`else
    return (size != SIZE_WORD) || (off != 2'b00);
`endif
  endfunction

endpackage

// File: rtl/load_store_lane_mod.sv
// Byte/half lane handling: load extraction with sign/zero extension and
// store merging of sub-word data into a previously read word. Combinational.
module load_store_lane_mod
  import load_store_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        offset_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] rd_word_i,
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] new_data_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merged_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    byte_sel = rd_word_i[7:0];
    case (offset_i)
      2'd0:    byte_sel = rd_word_i[7:0];
      2'd1:    byte_sel = rd_word_i[15:8];
      2'd2:    byte_sel = rd_word_i[23:16];
      default: byte_sel = rd_word_i[31:24];
    endcase
    half_sel = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    case (size_i)
      SIZE_BYTE: load_data_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:   load_data_o = rd_word_i;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with the store data
  always_comb begin
    merged_word_o = old_word_i;
    case (size_i)
      SIZE_BYTE: begin
        case (offset_i)
          2'd0:    merged_word_o[7:0]   = new_data_i[7:0];
          2'd1:    merged_word_o[15:8]  = new_data_i[7:0];
          2'd2:    merged_word_o[23:16] = new_data_i[7:0];
          default: merged_word_o[31:24] = new_data_i[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset_i[1]) merged_word_o[31:16] = new_data_i[15:0];
        else             merged_word_o[15:0]  = new_data_i[15:0];
      end
      default: merged_word_o = new_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit_mod.sv
// Load/store unit: drives a word-wide data memory from MEM-stage requests.
// Optional feature macro: LOAD_STORE_SUBWORD_EN enables byte/half accesses
// (extension on loads, read-modify-write on stores). Without it only aligned
// word accesses are accepted; everything else is answered with misalign_o.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only in IDLE, and the request
// fields are sampled only on that edge. rsp_valid_o is a one-cycle pulse with
// misalign_o and rsp_rdata_o valid alongside it; there is no back-pressure on
// the response.
module load_store_unit_mod
  import load_store_pkg::*;
#(
  parameter int N = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [N-1:0]      req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              misalign_o,
  output logic [N-1:0]      mem_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_en_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  lsu_state_e        state_q;
  logic              rsp_valid_q;
  logic              misalign_q;
  logic [DATA_W-1:0] rdata_q;
  logic [N-1:0]      mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] load_data;

`ifdef LOAD_STORE_SUBWORD_EN
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merged_word;

  load_store_lane_mod u_lane (
    .size_i        (size_q),
    .offset_i      (off_q),
    .unsigned_i    (uns_q),
    .rd_word_i     (mem_read_data_i),
    .old_word_i    (mem_read_data_i),
    .new_data_i    (wdata_q),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );
`else
  logic unused_req_unsigned;
  assign unused_req_unsigned = req_unsigned_i;
  assign load_data = mem_read_data_i;
`endif

  // Request sequencing FSM; every output is a register or a state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef LOAD_STORE_SUBWORD_EN
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdata_q <= '0;
          if (req_valid_i) begin
            if (req_illegal(req_size_i, req_addr_i[1:0])) begin
              // Rejected without touching memory; response goes out next cycle
              state_q     <= ST_ERR;
              rsp_valid_q <= 1'b1;
              misalign_q  <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr_i[N-1:2], 2'b00};
`ifdef LOAD_STORE_SUBWORD_EN
              off_q      <= req_addr_i[1:0];
              size_q     <= req_size_i;
              uns_q      <= req_unsigned_i;
              wdata_q    <= req_wdata_i;
`endif
              if (!req_we_i) begin
                state_q <= ST_LOAD;
`ifdef LOAD_STORE_SUBWORD_EN
              end else if (req_size_i != SIZE_WORD) begin
                state_q <= ST_RMW_RD;
`endif
              end else begin
                state_q     <= ST_WRITE;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata_i;
              end
            end
          end
        end
        ST_LOAD: begin
          rdata_q     <= load_data;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RMW_RD: begin
`ifdef LOAD_STORE_SUBWORD_EN
          mem_wdata_q <= merged_word;
          mem_we_q    <= 1'b1;
          state_q     <= ST_WRITE;
`else
          state_q     <= ST_IDLE;
`endif
        end
        ST_WRITE: begin
          rdata_q     <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == ST_IDLE);
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rdata_q;
  assign misalign_o       = misalign_q;
  assign mem_address_o    = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;
  assign mem_write_en_o   = mem_we_q;

endmodule

// File: tb/tb_load_store_unit_mod.sv
// Bench for load_store_unit_mod: directed requests, scoreboard of expected
// responses (data, misalign flag, response cycle, write-enable count).
module tb_load_store_unit_mod;

  localparam int N = 10;
`ifdef LOAD_STORE_SUBWORD_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b10;
  logic        req_unsigned_i = 1'b0;
  logic [N-1:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        misalign_o;
  logic [N-1:0] mem_address_o;
  logic [31:0] mem_write_data_o;
  logic        mem_write_en_o;
  logic [31:0] mem_read_data_i;

  load_store_unit_mod #(.N(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .misalign_o       (misalign_o),
    .mem_address_o    (mem_address_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_write_en_o   (mem_write_en_o),
    .mem_read_data_i  (mem_read_data_i)
  );

  // ---------------- data memory model ----------------
  logic [31:0] mem [256];
  assign mem_read_data_i = mem[mem_address_o[N-1:2]];
  always @(posedge clk) if (mem_write_en_o) mem[mem_address_o[N-1:2]] <= mem_write_data_o;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];
  int          exp_cyc_q[$];
  int          exp_we_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each response pulse against the oldest expectation
  int   we_cnt = 0;
  logic prev_rsp = 1'b0;
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      we_cnt = 0;
      prev_rsp = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (mem_write_en_o) begin
        we_cnt++;
        chk("we_back_to_back", 32'(prev_we), 32'd0);
      end
      if (rsp_valid_o) begin
        chk("rsp_single_pulse", 32'(prev_rsp), 32'd0);
        chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("rsp_rdata", rsp_rdata_o, exp_q.pop_front());
          chk("rsp_misalign", 32'(misalign_o), 32'(exp_mis_q.pop_front()));
          chk("rsp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
          chk("rsp_we_count", 32'(we_cnt), 32'(exp_we_q.pop_front()));
        end
        we_cnt = 0;
      end
      prev_rsp = rsp_valid_o;
      prev_we  = mem_write_en_o;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(req_ready_o), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [N-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err);
    int lat;
    wait_ready();
    #1;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    if (exp_err) lat = 0;
    else if (we && size != 2'b10) lat = 2;
    else lat = 1;
    exp_q.push_back(exp_data);
    exp_mis_q.push_back(exp_err);
    exp_cyc_q.push_back(cyc + 1 + lat);
    exp_we_q.push_back((we && !exp_err) ? 1 : 0);
    @(posedge clk);
    #1;
    // Scramble fields after acceptance; the unit must have latched them
    req_valid_i    = 1'b0;
    req_we_i       = 1'(~we);
    req_size_i     = 2'($urandom_range(0, 3));
    req_unsigned_i = 1'(~uns);
    req_addr_i     = N'($urandom);
    req_wdata_i    = $urandom;
  endtask

  // Sub-word access: real result with the feature, a rejection without it
  task automatic sub_issue(input logic we, input logic [1:0] size, input logic uns,
                           input logic [N-1:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data);
    issue(we, size, uns, addr, wdata, SUB_EN ? exp_data : 32'h0, !SUB_EN);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign_o), 32'd0);
    chk({tag, "_we"}, 32'(mem_write_en_o), 32'd0);
    chk({tag, "_addr"}, 32'(mem_address_o), 32'd0);
    chk({tag, "_wdata"}, mem_write_data_o, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'd4;
    mem[1] = 32'd6;
    mem[2] = 32'd8;
    mem[3] = 32'd55;
    mem[4] = 32'd133;
    mem[5] = 32'd255;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready_o), 32'd1);

    // Loads
    issue(1'b0, 2'b10, 1'b0, 10'd4, 32'h0, 32'd6, 1'b0);
    sub_issue(1'b0, 2'b00, 1'b0, 10'd16, 32'h0, 32'hFFFFFF85);
    sub_issue(1'b0, 2'b00, 1'b1, 10'd16, 32'h0, 32'h00000085);
    sub_issue(1'b0, 2'b01, 1'b0, 10'd20, 32'h0, 32'h000000FF);

    // Word store then read back
    issue(1'b1, 2'b10, 1'b0, 10'd0, 32'd100, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 10'd0, 32'h0, 32'd100, 1'b0);

    // Sub-word stores and read back through the unit
    sub_issue(1'b1, 2'b00, 1'b0, 10'd13, 32'hFFFFFFAB, 32'h0);
    sub_issue(1'b1, 2'b01, 1'b0, 10'd22, 32'h00001234, 32'h0);
    sub_issue(1'b0, 2'b00, 1'b0, 10'd13, 32'h0, 32'hFFFFFFAB);
    sub_issue(1'b0, 2'b01, 1'b1, 10'd22, 32'h0, 32'h00001234);
    sub_issue(1'b0, 2'b00, 1'b1, 10'd23, 32'h0, 32'h00000012);

    // Rejections: misaligned word, illegal size, misaligned half / word store
    issue(1'b0, 2'b10, 1'b0, 10'd6, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 10'd8, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 10'd8, 32'hDEADBEEF, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 10'd9, 32'h0000BEEF, 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 10'd10, 32'hCAFEF00D, 32'h0, 1'b1);
    drain();

    chk("mem_word0", mem[0], 32'd100);
    chk("mem_word12", mem[3], SUB_EN ? 32'h0000AB37 : 32'h00000037);
    chk("mem_word20", mem[5], SUB_EN ? 32'h123400FF : 32'h000000FF);
    chk("mem_word8_after_rejects", mem[2], 32'd8);

    // Reset in the middle of a store: no write, no response
    wait_ready();
    #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = SUB_EN ? 2'b00 : 2'b10;
    req_addr_i  = SUB_EN ? 10'd9 : 10'd8;
    req_wdata_i = 32'h00000077;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready_o), 32'd1);
    chk("mem_word8_after_abort", mem[2], 32'd8);

    issue(1'b0, 2'b10, 1'b0, 10'd8, 32'h0, 32'd8, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 10'd24, 32'h5A5A0001, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b1, 10'd24, 32'h0, 32'h5A5A0001, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
